// File: rtl/dsp_result_buffer_pkg.sv
// Shared definitions for the DSP output-side blocks.
// Holds the default result width and the pointer/count width rules.
package dsp_result_buffer_pkg;

   localparam int unsigned DSP_P_WIDTH = 48;

   // Address width for a storage array of the given depth.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Occupancy counters need to represent 0..depth inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/dsp_result_ram.sv
// DEPTH x WIDTH register array with a synchronous write and a combinational read.
// Contents are not reset; the control logic masks stale data.
module dsp_result_ram
   import dsp_result_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = DSP_P_WIDTH,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/dsp_result_buffer.sv
// Small FIFO draining registered DSP results to a downstream consumer.
// Valid/ready on both sides, clock-enable gating and a sticky overflow flag.
module dsp_result_buffer
   import dsp_result_buffer_pkg::*;
#(
   parameter int unsigned WIDTH = DSP_P_WIDTH,
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          CE,
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [WIDTH-1:0]              out_data,
   input  logic                          out_ready,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          overflow
);

   localparam int unsigned AW = ptr_width(DEPTH);
   localparam int unsigned CW = count_width(DEPTH);

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_overflow;
   logic             w_wr;
   logic             w_rd;
   logic             w_drop;
   logic [WIDTH-1:0] w_rd_data;

   // Flow control decodes only from registered occupancy.
   assign in_ready  = (r_count != CW'(DEPTH));
   assign out_valid = (r_count != '0);
   assign w_wr      = CE & in_valid & in_ready;
   assign w_rd      = CE & out_valid & out_ready;
   assign w_drop    = CE & in_valid & ~in_ready;

   assign out_data  = out_valid ? w_rd_data : '0;
   assign count     = r_count;
   assign overflow  = r_overflow;

   dsp_result_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .i_we      (w_wr),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (in_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (CE) begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) r_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dsp_result_buffer.sv
// Randomized and directed bench for dsp_result_buffer.
// A queue-based reference FIFO feeds expected words to an independent output monitor.
module tb_dsp_result_buffer;

   localparam int unsigned WIDTH = 48;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic             CE;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CW-1:0]    count;
   logic             overflow;

   int               errors = 0;
   int               checks = 0;
   logic [WIDTH-1:0] exp_q[$];
   int               ref_cnt = 0;
   bit               ref_ovf = 0;

   dsp_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .CE        (CE),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, " count"},    64'(count),     64'(ref_cnt));
      chk({tag, " in_ready"}, 64'(in_ready),  64'(ref_cnt != DEPTH));
      chk({tag, " out_valid"},64'(out_valid), 64'(ref_cnt != 0));
      chk({tag, " overflow"}, 64'(overflow),  64'(ref_ovf));
   endtask

   // One cycle of stimulus; called at posedge+2, returns at the next posedge+2.
   task automatic step(input bit ce, input bit iv, input logic [WIDTH-1:0] din, input bit ordy,
                       input string tag);
      bit acc_w, acc_r, drop;
      CE        = ce;
      in_valid  = iv;
      in_data   = din;
      out_ready = ordy;
      acc_w = ce && iv && (ref_cnt < DEPTH);
      acc_r = ce && ordy && (ref_cnt > 0);
      drop  = ce && iv && (ref_cnt == DEPTH);
      if (acc_w) exp_q.push_back(din);
      @(posedge clk);
      #1;
      if (acc_w) ref_cnt++;
      if (acc_r) ref_cnt--;
      if (drop)  ref_ovf = 1;
      chk_flags(tag);
      #1;
   endtask

   // Reset asserted between edges; effects must be visible before the next edge.
   task automatic async_reset(input string tag);
      rst       = 1'b1;
      CE        = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      exp_q.delete();
      ref_cnt = 0;
      ref_ovf = 0;
      chk_flags(tag);
      chk({tag, " out_data"}, 64'(out_data), 64'(0));
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Monitor: compares the presented word against the reference FIFO head.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL monitor: out_valid with empty reference, data %0h", out_data);
            end else begin
               chk("out_data", 64'(out_data), 64'(exp_q[0]));
               if (CE && out_ready) void'(exp_q.pop_front());
            end
         end else begin
            chk("out_data empty", 64'(out_data), 64'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; CE = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      chk_flags("power-on");
      chk("power-on out_data", 64'(out_data), 64'(0));
      @(posedge clk);
      #2;
      rst = 1'b0;
      step(1, 0, '0, 0, "idle");
      async_reset("reset idle");

      // Fill, then an ignored-backpressure write.
      for (int i = 1; i <= 4; i++) step(1, 1, WIDTH'(i), 0, "fill");
      chk("fill head", 64'(out_data), 64'(1));
      step(1, 1, WIDTH'(5), 0, "overflow");
      for (int i = 0; i < 4; i++) step(1, 0, '0, 1, "drain");
      step(1, 0, '0, 1, "drained idle");
      async_reset("reset clears ovf");

      // Streaming with both sides always ready.
      for (int i = 0; i < 16; i++) step(1, 1, WIDTH'(16 + i), 1, "stream");
      step(1, 0, '0, 1, "stream tail");

      // Clock-enable gating with two words held.
      step(1, 1, WIDTH'(48'hA1), 0, "ce pre");
      step(1, 1, WIDTH'(48'hA2), 0, "ce pre");
      for (int i = 0; i < 5; i++) step(0, 1, WIDTH'(48'hEE), 1, "ce off");
      chk("ce hold head", 64'(out_data), 64'(48'hA1));
      step(1, 0, '0, 1, "ce resume");
      step(1, 1, WIDTH'(48'hA3), 1, "ce resume");
      step(1, 0, '0, 1, "ce resume");
      step(1, 0, '0, 1, "ce resume");

      // Asynchronous reset with three words held.
      for (int i = 0; i < 3; i++) step(1, 1, WIDTH'(48'h30 + i), 0, "pre-reset");
      chk("pre-reset count", 64'(count), 64'(3));
      async_reset("reset mid-stream");
      step(1, 1, WIDTH'(48'hAA), 0, "post-reset write");
      chk("post-reset head", 64'(out_data), 64'(48'hAA));
      step(1, 0, '0, 1, "post-reset read");

      // Random traffic against the reference FIFO.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0,
              WIDTH'({$urandom, $urandom}), $urandom_range(0, 2) == 0, "random");
      end
      for (int i = 0; i < DEPTH + 1; i++) step(1, 0, '0, 1, "final drain");
      chk("reference empty", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dsp_result_buffer.md
Name: dsp_result_buffer

Overview:
- Output-side counterpart to the DSP input-capture register stages: drains registered DSP results (P/PCOUT path) toward a downstream consumer.
- Small synchronous FIFO with a valid/ready handshake on both sides and clock-enable gating.
- Adds a sticky overflow flag for producers that ignore backpressure.
- Sits between the DSP output register and the system bus or next processing slice.

Parameters:
- WIDTH, 48, data width of one result word.
- DEPTH, 4, number of storage entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- CE  input  1  clock enable; when 0, all state (storage, pointers, count, overflow) holds.
- in_valid  input  1  producer presents in_data.
- in_data  input  WIDTH  result word from the DSP output register.
- in_ready  output  1  buffer can accept a word (not full).
- out_valid  output  1  out_data holds a valid word (not empty).
- out_data  output  WIDTH  oldest stored word.
- out_ready  input  1  consumer accepts out_data.
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers = 0, count = 0, overflow = 0.
  - in_ready = 1, out_valid = 0, out_data = 0.
  - Storage contents are don't-care.
- Handshake:
  - wr = CE & in_valid & in_ready.
  - rd = CE & out_valid & out_ready.
  - A word transfers only on a posedge where its strobe is 1.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both decode combinationally from registered count and never depend on in_valid or out_ready in the same cycle.
- out_data = storage[rd_ptr], a combinational read of registered storage. When empty it is forced to 0.
- Latency: a word written at edge N produces out_valid = 1 from edge N onward (visible in cycle N+1). There is no same-cycle pass-through.
- Occupancy states are derived from count:
  - EMPTY (0): wr -> PARTIAL, or FULL if DEPTH is 1 (DEPTH is never 1 here).
  - PARTIAL: wr only -> count+1; rd only -> count-1; wr&rd -> count unchanged.
  - FULL (DEPTH): rd -> PARTIAL. No write is possible because in_ready = 0.
- Simultaneous wr & rd in PARTIAL: both pointers advance, count holds, and FIFO order is preserved.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Overflow:
  - Set when CE & in_valid & ~in_ready. The word is dropped and storage is unchanged.
  - Cleared only by rst.
- CE = 0: no transfers and no flag updates, whatever in_valid and out_ready are. Outputs still reflect the held state.
- Reset mid-operation: contents are discarded immediately (asynchronously). out_valid falls without waiting for an edge.

Decomposition:
- Shared header/package holds:
  - default WIDTH (48, the DSP P width);
  - the pointer-width function ($clog2 wrapper);
  - the COUNT_W derivation rule, used by all output-side DSP blocks.
- A single sub-module is natural: dsp_result_ram (DEPTH x WIDTH register array with write enable and combinational read). The control logic stays in dsp_result_buffer.

Test Plan:
- Reset then idle: assert rst mid-cycle -> immediately in_ready = 1, out_valid = 0, count = 0, overflow = 0, out_data = 0.
- Fill: CE = 1, out_ready = 0, write 0x1, 0x2, 0x3, 0x4 on 4 edges -> count = 4, in_ready = 0, out_valid = 1, out_data = 0x1, overflow = 0.
- Overflow: from full, in_valid = 1 with in_data = 0x5 for 1 edge -> overflow = 1, count stays 4. Drain -> reads 0x1..0x4 only; overflow stays 1 until rst.
- Streaming: in_valid = out_ready = 1 every cycle with data 0x10..0x1F, starting empty:
  - count goes 0 -> 1, then holds at 1;
  - outputs are 0x10..0x1F in order, each 1 cycle after its write;
  - pointers wrap at least 3 times.
- CE gating: buffer holds 2 words; CE = 0 for 5 cycles with in_valid = out_ready = 1 -> count, out_data and overflow unchanged. Restoring CE = 1 resumes transfers.
- Async reset mid-stream: count = 3, assert rst between edges -> out_valid = 0 and count = 0 before the next posedge. After release, the first write 0xAA reads back as 0xAA.
